servo_pwm_array: RTL

Parametrised multi-channel servo PWM generator: the successor to the single-channel servo controller. It drives CHANNELS servo outputs from one shared period counter. Each channel has an 8-bit position register, a glitch-free update at the period boundary, and optional per-period slew limiting. The block sits between the switch/host register interface and the servo header pins.

---
 rtl/servo_pwm_array.sv | 138 +++++++++++++
 1 files changed

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel position
// targets written through a two-stage pipeline, and per-frame (optionally slew-limited) pulse updates.
module servo_pwm_array #(
    parameter int CLK_FREQ  = 50000000,
    parameter int PWM_FREQ  = 50,
    parameter int CHANNELS  = 4,
    parameter int MIN_US    = 500,
    parameter int MAX_US    = 2500,
    parameter int SLEW_STEP = 0,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic [CHANNELS-1:0] ch_enable_i,
    input  logic                wr_en_i,
    input  logic [CH_W-1:0]     wr_ch_i,
    input  logic [7:0]          wr_pos_i,
    output logic                wr_err_o,
    output logic                period_start_o,
    output logic [CHANNELS-1:0] servo_pwm_o
);

    localparam int P        = CLK_FREQ / PWM_FREQ;
    localparam int MIN_T    = CLK_FREQ / 1000000 * MIN_US;
    localparam int MAX_T    = CLK_FREQ / 1000000 * MAX_US;
    localparam int SPAN     = MAX_T - MIN_T;
    localparam int CENTER   = (MIN_T + MAX_T) / 2;
    localparam int CNT_W    = $clog2(P);
    localparam int ACT_W    = $clog2(MAX_T + 1);
    localparam int SPAN_W   = $clog2(SPAN + 1);
    localparam int PROD_W   = 8 + SPAN_W;
    localparam int STEP_C   = (SLEW_STEP > SPAN) ? SPAN : SLEW_STEP;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(P - 1);
    localparam logic [ACT_W-1:0]  CENTER_T = ACT_W'(CENTER);
    localparam logic [ACT_W-1:0]  MIN_TT   = ACT_W'(MIN_T);
    localparam logic [ACT_W-1:0]  STEP_T   = ACT_W'(STEP_C);
    localparam logic [PROD_W-1:0] SPAN_P   = PROD_W'(SPAN);
    localparam logic [PROD_W-1:0] DIV_P    = PROD_W'(255);
    localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(CHANNELS);

    if (MIN_T < 1 || MAX_T >= P || MAX_T <= MIN_T) begin : g_bad_timing
        $error("servo_pwm_array: need 1 <= MIN_T < MAX_T < P");
    end

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                s1_valid_q;
    logic [CH_W-1:0]     s1_ch_q;
    logic [PROD_W-1:0]   s1_prod_q;
    logic [ACT_W-1:0]    target_q [CHANNELS];
    logic [ACT_W-1:0]    act_q    [CHANNELS];
    logic [ACT_W-1:0]    act_d    [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                period_start_q;
    logic                wr_err_q;

    logic                frame_edge;
    logic                wr_ok;
    logic [PROD_W-1:0]   wr_prod;
    logic [PROD_W-1:0]   quot;
    logic [ACT_W-1:0]    new_target;

    assign frame_edge = enable_i && (cnt_q == '0);
    assign wr_ok      = ({1'b0, wr_ch_i} < CH_LIMIT);
    assign wr_prod    = PROD_W'(wr_pos_i) * SPAN_P;
    // Division by a constant: exact floor for every code, no reciprocal rounding to verify.
    assign quot       = s1_prod_q / DIV_P;
    assign new_target = MIN_TT + ACT_W'(quot);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // act only moves on the first cycle of a frame, so a running pulse is never reshaped.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            act_d[i] = act_q[i];
            if (frame_edge) begin
                if (SLEW_STEP == 0 || target_q[i] == act_q[i]) begin
                    act_d[i] = target_q[i];
                end else if (target_q[i] > act_q[i]) begin
                    act_d[i] = ((target_q[i] - act_q[i]) > STEP_T) ? act_q[i] + STEP_T : target_q[i];
                end else begin
                    act_d[i] = ((act_q[i] - target_q[i]) > STEP_T) ? act_q[i] - STEP_T : target_q[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable_i && ch_enable_i[i] && (32'(cnt_q) < 32'(act_d[i]));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q          <= '0;
            s1_valid_q     <= 1'b0;
            s1_ch_q        <= '0;
            s1_prod_q      <= '0;
            wr_err_q       <= 1'b0;
            period_start_q <= 1'b0;
            pwm_q          <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= CENTER_T;
                act_q[i]    <= CENTER_T;
            end
        end else begin
            cnt_q          <= cnt_d;
            s1_valid_q     <= wr_en_i && wr_ok;
            s1_ch_q        <= wr_ch_i;
            s1_prod_q      <= wr_prod;
            wr_err_q       <= wr_en_i && !wr_ok;
            period_start_q <= frame_edge;
            pwm_q          <= pwm_d;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s1_valid_q && (s1_ch_q == CH_W'(i))) begin
                    target_q[i] <= new_target;
                end
                act_q[i] <= act_d[i];
            end
        end
    end

    assign wr_err_o       = wr_err_q;
    assign period_start_o = period_start_q;
    assign servo_pwm_o    = pwm_q;

endmodule
